tteframe_dispatch: RTL and testbench



---
 rtl/tteframe_dispatch_pkg.sv | 36 +++
 rtl/tteframe_dispatch_if.sv | 50 +++++
 rtl/tteframe_dispatch_buf_space_tracker.sv | 50 +++++
 rtl/tteframe_dispatch.sv | 194 +++++++++++++++++++
 tb/tb_tteframe_dispatch.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tteframe_dispatch_pkg.sv
// Shared switch-core definitions for the frame dispatch block.
// Holds the dispatch FSM state encoding, the descriptor field widths,
// the layout of the first header byte and small helper functions.
package tteframe_dispatch_pkg;

    localparam int NPORT  = 4;   // egress ports served by one descriptor push
    localparam int LEN_W  = 12;  // length field carried in the stream header
    localparam int DLEN_W = 11;  // length field stored in a descriptor

    // Header byte 0 layout: {len_hi[3:0], portmap[3:0]}
    localparam int HDR_LEN_HI_MSB  = 7;
    localparam int HDR_LEN_HI_LSB  = 4;
    localparam int HDR_PORTMAP_MSB = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR2   = 3'd1,
        DATA   = 3'd2,
        COMMIT = 3'd3,
        DROP   = 3'd4
    } state_t;

    function automatic logic [3:0] hdr_len_hi(input logic [7:0] b);
        return b[HDR_LEN_HI_MSB:HDR_LEN_HI_LSB];
    endfunction

    function automatic logic [NPORT-1:0] hdr_portmap(input logic [7:0] b);
        return b[HDR_PORTMAP_MSB:0];
    endfunction

    // Drop counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tteframe_dispatch_if.sv
// Bus bundle between the frame-processing stage, the dispatch block,
// the shared frame buffer and the per-port descriptor FIFOs.
//
// Transfer rules (the only handshake semantics on this bundle):
//   - Stream: no ready. A byte moves on every clock where dv is high; sof
//     marks byte 0 and is meaningful only together with dv. bp0..bp3 are
//     advisory backpressure that the producer honours at frame boundaries.
//   - Release: rel_valid is a single-cycle pulse, one per released frame,
//     qualifying rel_len in that same cycle.
//   - Buffer write / descriptor push: fire-and-forget strobes (dbuf_wr,
//     ptr_wr[n]) with no ready; FIFO fullness is consulted via ptr_full
//     when a frame header is accepted.
//
// master: the surrounding switch core (drives stream, fullness, releases)
// slave : tteframe_dispatch
interface tteframe_dispatch_if #(
    parameter int AW = 12
);
    import tteframe_dispatch_pkg::*;

    logic                    sof;
    logic                    dv;
    logic [7:0]              data;
    logic [NPORT-1:0]        ptr_full;
    logic                    rel_valid;
    logic [DLEN_W-1:0]       rel_len;
    logic                    dbuf_wr;
    logic [AW-1:0]           dbuf_addr;
    logic [7:0]              dbuf_din;
    logic [NPORT-1:0]        ptr_wr;
    logic [AW+DLEN_W-1:0]    ptr_din;
    logic                    bp0;
    logic                    bp1;
    logic                    bp2;
    logic                    bp3;
    logic [15:0]             drop_cnt;

    modport master (
        output sof, dv, data, ptr_full, rel_valid, rel_len,
        input  dbuf_wr, dbuf_addr, dbuf_din, ptr_wr, ptr_din,
        input  bp0, bp1, bp2, bp3, drop_cnt
    );

    modport slave (
        input  sof, dv, data, ptr_full, rel_valid, rel_len,
        output dbuf_wr, dbuf_addr, dbuf_din, ptr_wr, ptr_din,
        output bp0, bp1, bp2, bp3, drop_cnt
    );

endinterface

// File: rtl/tteframe_dispatch_buf_space_tracker.sv
// buf_space_tracker: free-space accounting for the shared frame buffer.
// Ports:
//   clk, rst     - core clock, synchronous active-high reset
//   commit       - a stored frame is being committed this cycle
//   commit_len   - byte length of the committed frame
//   rel_valid    - downstream released a frame this cycle
//   rel_len      - byte length of the released frame
//   free_cnt     - free bytes, 0 .. 2^AW (registered)
//   below        - free_cnt is under the MAX_LEN threshold
module buf_space_tracker
    import tteframe_dispatch_pkg::*;
#(
    parameter int AW      = 12,
    parameter int MAX_LEN = 1536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit,
    input  logic [LEN_W-1:0]  commit_len,
    input  logic              rel_valid,
    input  logic [DLEN_W-1:0] rel_len,
    output logic [AW:0]       free_cnt,
    output logic              below
);

    // Headroom so free + release never overflows before the clamp.
    localparam int SW = AW + LEN_W + 1;
    localparam logic [AW:0]   CAP       = {1'b1, {AW{1'b0}}};
    localparam logic [31:0]   MAX_LEN_U = 32'(MAX_LEN);

    logic [SW-1:0] sum;
    logic [AW:0]   free_nxt;

    // Commit and release in the same cycle net out; the result is clamped
    // because a release may never claim more space than the buffer holds.
    always_comb begin
        sum = SW'(free_cnt);
        if (rel_valid) sum = sum + SW'(rel_len);
        if (commit)    sum = sum - SW'(commit_len);
        free_nxt = (sum > SW'(CAP)) ? CAP : sum[AW:0];
    end

    always_ff @(posedge clk) begin
        if (rst) free_cnt <= CAP;
        else     free_cnt <= free_nxt;
    end

    assign below = (32'(free_cnt) < MAX_LEN_U);

endmodule

// File: rtl/tteframe_dispatch.sv
// tteframe_dispatch: receive side of the internal frame stream.
// Parses {len_hi,portmap},{len_lo} headers, writes the frame body into the
// shared frame buffer, pushes one descriptor to every eligible egress port,
// counts dropped frames and drives per-port backpressure.
// Ports:
//   clk, rst      - core clock, synchronous active-high reset
//   bus (slave)   - stream in, ptr_full, releases; buffer writes,
//                   descriptor pushes, bp0..bp3, drop_cnt out
//   dbg_state     - current FSM state
//   dbg_free_cnt  - current buffer free-space count
module tteframe_dispatch
    import tteframe_dispatch_pkg::*;
#(
    parameter int AW      = 12,
    parameter int MAX_LEN = 1536
) (
    input  logic               clk,
    input  logic               rst,
    tteframe_dispatch_if.slave bus,
    output state_t             dbg_state,
    output logic [AW:0]        dbg_free_cnt
);

    localparam logic [31:0] MAX_LEN_U = 32'(MAX_LEN);

    state_t                 state;
    logic [NPORT-1:0]       portmap_q;
    logic [3:0]             len_hi_q;
    logic [LEN_W-1:0]       len_q;
    logic [NPORT-1:0]       emap_q;
    logic [AW-1:0]          start_q;
    logic [AW-1:0]          wr_ptr;
    logic [LEN_W-1:0]       cnt_q;

    logic                   dbuf_wr_q;
    logic [AW-1:0]          dbuf_addr_q;
    logic [7:0]             dbuf_din_q;
    logic [NPORT-1:0]       ptr_wr_q;
    logic [AW+DLEN_W-1:0]   ptr_din_q;
    logic [15:0]            drop_cnt_q;
    logic [NPORT-1:0]       bp_q;

    logic [AW:0]            free_cnt;
    logic                   below;
    logic [LEN_W-1:0]       len_full;
    logic [NPORT-1:0]       emap_c;
    logic                   reject;

    buf_space_tracker #(
        .AW      (AW),
        .MAX_LEN (MAX_LEN)
    ) u_space (
        .clk        (clk),
        .rst        (rst),
        .commit     (state == COMMIT),
        .commit_len (len_q),
        .rel_valid  (bus.rel_valid),
        .rel_len    (bus.rel_len),
        .free_cnt   (free_cnt),
        .below      (below)
    );

    // Header decision, evaluated while byte 1 is on the stream. The frame is
    // refused up front if it can never be stored completely, so the buffer
    // never holds a partial frame that outlives its own dv window.
    assign len_full = {len_hi_q, bus.data};
    assign emap_c   = portmap_q & ~bus.ptr_full;
    assign reject   = (len_full == '0)
                   || (32'(len_full) > MAX_LEN_U)
                   || (emap_c == '0)
                   || (32'(free_cnt) < 32'(len_full));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            portmap_q   <= '0;
            len_hi_q    <= '0;
            len_q       <= '0;
            emap_q      <= '0;
            start_q     <= '0;
            wr_ptr      <= '0;
            cnt_q       <= '0;
            dbuf_wr_q   <= 1'b0;
            dbuf_addr_q <= '0;
            dbuf_din_q  <= '0;
            ptr_wr_q    <= '0;
            ptr_din_q   <= '0;
            drop_cnt_q  <= '0;
            bp_q        <= '0;
        end else begin
            dbuf_wr_q <= 1'b0;
            ptr_wr_q  <= '0;
            bp_q      <= bus.ptr_full | {NPORT{below}};

            case (state)
                IDLE: begin
                    if (bus.dv && bus.sof) begin
                        portmap_q <= hdr_portmap(bus.data);
                        len_hi_q  <= hdr_len_hi(bus.data);
                        state     <= HDR2;
                    end
                end

                HDR2: begin
                    if (!bus.dv) begin
                        drop_cnt_q <= sat_inc16(drop_cnt_q);
                        state      <= IDLE;
                    end else if (bus.sof) begin
                        // A fresh header replaces the half-received one.
                        drop_cnt_q <= sat_inc16(drop_cnt_q);
                        portmap_q  <= hdr_portmap(bus.data);
                        len_hi_q   <= hdr_len_hi(bus.data);
                        state      <= HDR2;
                    end else begin
                        len_q   <= len_full;
                        emap_q  <= emap_c;
                        start_q <= wr_ptr;
                        cnt_q   <= '0;
                        state   <= reject ? DROP : DATA;
                    end
                end

                DATA: begin
                    if (bus.dv && bus.sof) begin
                        wr_ptr     <= start_q;
                        drop_cnt_q <= sat_inc16(drop_cnt_q);
                        portmap_q  <= hdr_portmap(bus.data);
                        len_hi_q   <= hdr_len_hi(bus.data);
                        state      <= HDR2;
                    end else if (bus.dv) begin
                        // Bytes past len are pad and never reach the buffer.
                        if (cnt_q < len_q) begin
                            dbuf_wr_q   <= 1'b1;
                            dbuf_addr_q <= wr_ptr;
                            dbuf_din_q  <= bus.data;
                            wr_ptr      <= wr_ptr + AW'(1);
                            cnt_q       <= cnt_q + LEN_W'(1);
                        end
                    end else if (cnt_q == len_q) begin
                        ptr_wr_q  <= emap_q;
                        ptr_din_q <= {start_q, len_q[DLEN_W-1:0]};
                        state     <= COMMIT;
                    end else begin
                        // Runt: give the space back to the next frame.
                        wr_ptr     <= start_q;
                        drop_cnt_q <= sat_inc16(drop_cnt_q);
                        state      <= IDLE;
                    end
                end

                COMMIT: begin
                    // The next frame may already start here; free_cnt is
                    // charged by the tracker in this same cycle.
                    if (bus.dv && bus.sof) begin
                        portmap_q <= hdr_portmap(bus.data);
                        len_hi_q  <= hdr_len_hi(bus.data);
                        state     <= HDR2;
                    end else begin
                        state <= IDLE;
                    end
                end

                DROP: begin
                    if (bus.dv && bus.sof) begin
                        drop_cnt_q <= sat_inc16(drop_cnt_q);
                        portmap_q  <= hdr_portmap(bus.data);
                        len_hi_q   <= hdr_len_hi(bus.data);
                        state      <= HDR2;
                    end else if (!bus.dv) begin
                        drop_cnt_q <= sat_inc16(drop_cnt_q);
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dbuf_wr   = dbuf_wr_q;
    assign bus.dbuf_addr = dbuf_addr_q;
    assign bus.dbuf_din  = dbuf_din_q;
    assign bus.ptr_wr    = ptr_wr_q;
    assign bus.ptr_din   = ptr_din_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.bp0       = bp_q[0];
    assign bus.bp1       = bp_q[1];
    assign bus.bp2       = bp_q[2];
    assign bus.bp3       = bp_q[3];

    assign dbg_state     = state;
    assign dbg_free_cnt  = free_cnt;

endmodule

// File: tb/tb_tteframe_dispatch.sv
// Testbench for tteframe_dispatch: directed scenarios followed by random
// frames, scored against a frame-level reference model.
module tb_tteframe_dispatch;
    import tteframe_dispatch_pkg::*;

    localparam int AW      = 12;
    localparam int MAX_LEN = 1536;
    localparam int CAP     = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tteframe_dispatch_if #(.AW(AW)) bus ();
    state_t      dbg_state;
    logic [AW:0] dbg_free_cnt;

    tteframe_dispatch #(.AW(AW), .MAX_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dbg_state    (dbg_state),
        .dbg_free_cnt (dbg_free_cnt)
    );

    // ---------------- reference model state ----------------
    int         checks = 0;
    int         errors = 0;
    int         m_wr   = 0;
    int         m_free = CAP;
    int         m_drop = 0;
    logic [3:0] m_pfull = 4'h0;

    // {cycle, addr, data} and {cycle, map, ptr_din}
    logic [63:0] exp_wr_q[$];
    logic [63:0] exp_desc_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        bus.sof       = s;
        bus.dv        = v;
        bus.data      = d;
        bus.rel_valid = 1'b0;
    endtask

    // n idle cycles; the first one carries a release when rel > 0
    task automatic idle(input int n, input int rel);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sof  = 1'b0;
            bus.dv   = 1'b0;
            bus.data = 8'($urandom);
            if (i == 0 && rel > 0) begin
                bus.rel_valid = 1'b1;
                bus.rel_len   = 11'(rel);
                m_free = (m_free + rel > CAP) ? CAP : m_free + rel;
            end else begin
                bus.rel_valid = 1'b0;
            end
        end
    endtask

    task automatic set_pfull(input logic [3:0] v);
        m_pfull      = v;
        bus.ptr_full = v;
    endtask

    // Sends a header plus nbody bytes. end_dv=0 leaves dv high so the next
    // frame's sof aborts this one.
    task automatic send_frame(input int len, input logic [3:0] pmap, input int nbody, input bit end_dv);
        bit         acc;
        logic [7:0] b;
        logic [3:0] emap;
        emap = pmap & ~m_pfull;
        acc  = (len != 0) && (len <= MAX_LEN) && (emap != 4'h0) && (m_free >= len);
        drive(1'b1, 1'b1, {len[11:8], pmap});
        drive(1'b0, 1'b1, len[7:0]);
        for (int i = 0; i < nbody; i++) begin
            b = 8'($urandom);
            drive(1'b0, 1'b1, b);
            if (acc && i < len)
                exp_wr_q.push_back((64'(cyc + 1) << (AW + 8)) | (64'((m_wr + i) % CAP) << 8) | 64'(b));
        end
        if (end_dv) begin
            drive(1'b0, 1'b0, 8'h00);
            if (acc && nbody >= len) begin
                exp_desc_q.push_back((64'(cyc + 1) << (4 + AW + DLEN_W)) | (64'(emap) << (AW + DLEN_W))
                                     | (64'(m_wr) << DLEN_W) | 64'(len));
                m_wr   = (m_wr + len) % CAP;
                m_free = m_free - len;
            end else begin
                m_drop++;
            end
        end else begin
            m_drop++;
        end
    endtask

    task automatic check_quiet(input string tag);
        idle(3, 0);
        check_eq({tag, "_drop"}, 64'(bus.drop_cnt), 64'(m_drop));
        check_eq({tag, "_free"}, 64'(dbg_free_cnt), 64'(m_free));
        check_eq({tag, "_bp"}, 64'({bus.bp3, bus.bp2, bus.bp1, bus.bp0}),
                 64'(m_pfull | {4{m_free < MAX_LEN}}));
        check_eq({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
        check_eq({tag, "_wr_pending"}, 64'(exp_wr_q.size()), 64'd0);
        check_eq({tag, "_desc_pending"}, 64'(exp_desc_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_dbuf_wr"}, 64'(bus.dbuf_wr), 64'd0);
        check_eq({tag, "_dbuf_addr"}, 64'(bus.dbuf_addr), 64'd0);
        check_eq({tag, "_dbuf_din"}, 64'(bus.dbuf_din), 64'd0);
        check_eq({tag, "_ptr_wr"}, 64'(bus.ptr_wr), 64'd0);
        check_eq({tag, "_ptr_din"}, 64'(bus.ptr_din), 64'd0);
        check_eq({tag, "_bp"}, 64'({bus.bp3, bus.bp2, bus.bp1, bus.bp0}), 64'd0);
        check_eq({tag, "_drop"}, 64'(bus.drop_cnt), 64'd0);
        check_eq({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
        check_eq({tag, "_free"}, 64'(dbg_free_cnt), 64'(CAP));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.dbuf_wr === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                check_eq("wr_unexpected", 64'(bus.dbuf_wr), 64'd0);
            end else begin
                e = exp_wr_q.pop_front();
                check_eq("wr_cycle", 64'(cyc), e >> (AW + 8));
                check_eq("wr_addr", 64'(bus.dbuf_addr), (e >> 8) & ((64'd1 << AW) - 1));
                check_eq("wr_data", 64'(bus.dbuf_din), e & 64'hFF);
            end
        end
        if (bus.ptr_wr !== 4'h0) begin
            if (exp_desc_q.size() == 0) begin
                check_eq("desc_unexpected", 64'(bus.ptr_wr), 64'd0);
            end else begin
                e = exp_desc_q.pop_front();
                check_eq("desc_cycle", 64'(cyc), e >> (4 + AW + DLEN_W));
                check_eq("desc_map", 64'(bus.ptr_wr), (e >> (AW + DLEN_W)) & 64'hF);
                check_eq("desc_din", 64'(bus.ptr_din), e & ((64'd1 << (AW + DLEN_W)) - 1));
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.sof = 1'b0; bus.dv = 1'b0; bus.data = 8'h00;
        bus.ptr_full = 4'h0; bus.rel_valid = 1'b0; bus.rel_len = 11'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        check_quiet("post_reset");

        // unicast, len 64 to port 1, 6 pad bytes
        send_frame(64, 4'h2, 70, 1'b1);
        check_quiet("unicast");

        // multicast with port 2 full
        set_pfull(4'b0100);
        send_frame(20, 4'hF, 20, 1'b1);
        check_quiet("mcast");
        set_pfull(4'h0);

        // runt, then a frame that must reuse the runt's start address
        send_frame(100, 4'h1, 80, 1'b1);
        check_quiet("runt");
        send_frame(30, 4'h4, 30, 1'b1);
        check_quiet("after_runt");

        // advance wr_ptr to 2^AW-10, then a wrapping frame
        while (m_wr != CAP - 10) begin
            int l;
            l = (CAP - 10 - m_wr > 1500) ? 1500 : CAP - 10 - m_wr;
            idle(1, 2047);
            send_frame(l, 4'h8, l, 1'b1);
        end
        idle(1, 2047);
        send_frame(64, 4'h2, 67, 1'b1);
        check_quiet("wrap");

        // space and backpressure; two big releases must clamp at 2^AW
        idle(1, 2047);
        idle(1, 2047);
        check_quiet("clamp");
        send_frame(1000, 4'h1, 1000, 1'b1);
        send_frame(1000, 4'h1, 1000, 1'b1);
        send_frame(1000, 4'h1, 1000, 1'b1);
        check_quiet("fill");
        send_frame(1200, 4'h1, 1200, 1'b1);
        check_quiet("nofit");
        send_frame(500, 4'h4, 500, 1'b1);
        idle(1, 1000);
        check_quiet("net_update");

        // abort by sof mid-frame
        send_frame(50, 4'h1, 20, 1'b0);
        send_frame(40, 4'h2, 40, 1'b1);
        check_quiet("abort");

        // reset mid-frame
        send_frame(100, 4'h1, 10, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        bus.dv = 1'b0;
        rst = 1'b0;
        m_wr = 0; m_free = CAP; m_drop = 0;
        check_quiet("mid_reset_idle");
        send_frame(33, 4'h8, 35, 1'b1);
        check_quiet("after_reset");

        // random frames
        for (int n = 0; n < 40; n++) begin
            int len, nb, r, mode;
            bit ed;
            r = $urandom_range(0, 19);
            if (r == 0)      len = 0;
            else if (r == 1) len = $urandom_range(MAX_LEN + 1, 4095);
            else             len = $urandom_range(1, 200);
            set_pfull(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            mode = $urandom_range(0, 3);
            ed   = 1'b1;
            if (mode <= 1)       nb = len + $urandom_range(0, 4);
            else if (mode == 2)  nb = (len > 0) ? $urandom_range(0, len - 1) : 0;
            else begin
                nb = $urandom_range(0, len + 2);
                ed = (n == 39);
            end
            if (len > MAX_LEN) nb = $urandom_range(0, 5);
            send_frame(len, 4'($urandom), nb, ed);
            if (ed && $urandom_range(0, 1) == 1) idle(1, $urandom_range(0, 2047));
        end
        check_quiet("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
